vscpu_mem_responder: RTL



---
 rtl/vscpu_mem_pkg.sv | 18 +
 rtl/vscpu_ram_core.sv | 32 +++
 rtl/vscpu_mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vscpu_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vscpu_mem_pkg : shared types and constants for the memory responder   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vscpu_mem_pkg;

  localparam int DATA_W         = 32;
  localparam int REL_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/vscpu_ram_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vscpu_ram_core : single-port synchronous RAM, read-old-on-write       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vscpu_ram_core
  import vscpu_mem_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read and write share one edge, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vscpu_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vscpu_mem_responder : CPU RAM responder with host program-load port   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vscpu_mem_responder
  import vscpu_mem_pkg::*;
#(
  parameter int SIZE       = 14,
  parameter int DEPTH      = 2**SIZE,
  parameter int LOAD_BASE  = 0,
  parameter int REL_CYCLES = REL_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [SIZE-1:0]   addr_toRAM,
  input  logic [DATA_W-1:0] data_toRAM,
  output logic [DATA_W-1:0] data_fromRAM,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_rst,
  output logic [SIZE:0]     ld_count,
  output logic              ld_overflow
);

  localparam logic [SIZE:0] DEPTH_C  = (SIZE+1)'(DEPTH);
  localparam logic [SIZE:0] BASE_C   = (SIZE+1)'(LOAD_BASE);
  localparam int            REL_LAST = (REL_CYCLES > 1) ? REL_CYCLES - 1 : 0;
  localparam int            REL_W    = (REL_CYCLES > 1) ? $clog2(REL_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [SIZE:0]     ptr_q, ptr_d;
  logic [SIZE:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [REL_W-1:0]  rel_q, rel_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              ld_ready_q, ld_ready_d;
  logic              rd_valid_q, rd_valid_d;

  logic              ram_we;
  logic              ram_re;
  logic [SIZE-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              accept;
  logic              in_range;

  assign accept   = ld_valid & ld_ready_q;
  assign in_range = (ptr_q < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rel_d      = rel_q;
    rd_valid_d = rd_valid_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = addr_toRAM;
    ram_wdata  = data_toRAM;
    case (state_q)
      RUN: begin
        ram_we     = wrEn;
        ram_re     = 1'b1;
        rd_valid_d = 1'b1;
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = BASE_C;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        ram_addr  = ptr_q[SIZE-1:0];
        ram_wdata = ld_data;
        if (accept) begin
          if (in_range) begin
            ram_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (cnt_q != DEPTH_C) cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (ld_last) begin
            state_d = RELEASE;
            rel_d   = '0;
          end
        end
      end
      RELEASE: begin
        // Hold the CPU in reset long enough that it sees at least one edge.
        if (rel_q == REL_W'(REL_LAST)) begin
          state_d = RUN;
          rel_d   = '0;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    cpu_rst_d  = (state_d != RUN);
    ld_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rel_q      <= '0;
      cpu_rst_q  <= 1'b0;
      ld_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rel_q      <= rel_d;
      cpu_rst_q  <= cpu_rst_d;
      ld_ready_q <= ld_ready_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  vscpu_ram_core #(
    .ADDR_W (SIZE),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // The array itself has no reset; masking gives a clean zero until the first read.
  assign data_fromRAM = rd_valid_q ? ram_rdata : '0;
  assign cpu_rst      = cpu_rst_q;
  assign ld_ready     = ld_ready_q;
  assign ld_count     = cnt_q;
  assign ld_overflow  = ovf_q;

endmodule
`default_nettype wire
